// File: rtl/mem_resp_pkg.sv
// Shared bus widths, response FSM state encoding and the address range helper
// for the mem_resp responder.
package mem_resp_pkg;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_MASK_WIDTH = BUS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    MRESP_IDLE = 2'd0,
    MRESP_WAIT = 2'd1,
    MRESP_RESP = 2'd2
  } mresp_state_e;

  // True when addr falls outside [base, base + span); one extra bit keeps the
  // upper bound from wrapping near the top of the address space.
  function automatic logic addr_out_of_range(
    input logic [BUS_ADDR_WIDTH-1:0] addr,
    input logic [BUS_ADDR_WIDTH-1:0] base,
    input logic [BUS_ADDR_WIDTH:0]   span
  );
    logic [BUS_ADDR_WIDTH:0] limit;
    limit = {1'b0, base} + span;
    return (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Request/response bus between a requester (master) and the mem_resp
// responder (slave).
interface mem_resp_if;
  import mem_resp_pkg::*;

  logic                      mem_req_i;
  logic                      mem_we_i;
  logic [BUS_ADDR_WIDTH-1:0] mem_addr_i;
  logic [BUS_DATA_WIDTH-1:0] mem_wdata_i;
  logic [BUS_MASK_WIDTH-1:0] mem_wmask_i;
  logic                      mem_ready_o;
  logic                      mem_rvalid_o;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata_o;
  logic                      mem_err_o;
  logic                      mem_rready_i;

  modport master (
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i, mem_rready_i,
    input  mem_ready_o, mem_rvalid_o, mem_rdata_o, mem_err_o
  );

  modport slave (
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i, mem_rready_i,
    output mem_ready_o, mem_rvalid_o, mem_rdata_o, mem_err_o
  );

endinterface

// File: rtl/mem_resp_array.sv
// Single-port word array: synchronous byte-masked write, registered read.
// Contents are intentionally never reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic                      re,
  input  logic [$clog2(DEPTH)-1:0]  idx,
  input  logic [BUS_MASK_WIDTH-1:0] wmask,
  input  logic [BUS_DATA_WIDTH-1:0] wdata,
  output logic [BUS_DATA_WIDTH-1:0] rdata
);

  // One narrow RAM per byte lane so each lane maps onto its own write enable;
  // the read register only moves on re, so it holds while a response waits.
  genvar gi;
  generate
    for (gi = 0; gi < BUS_MASK_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (we && wmask[gi]) begin
          lane_mem[idx] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          rd_reg <= lane_mem[idx];
        end
      end

      assign rdata[gi*8 +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/mem_resp.sv
// Memory responder: accepts one request at a time in IDLE, waits READ_LAT
// cycles for reads, then holds the response until the consumer takes it.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int                        DEPTH     = 1024,
  parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int                        READ_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  mem_resp_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [BUS_ADDR_WIDTH:0] SPAN = (BUS_ADDR_WIDTH + 1)'(4 * DEPTH);
  localparam logic [1:0] CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  mresp_state_e              state_reg;
  logic [1:0]                cnt_reg;
  logic                      rvalid_reg;
  logic                      err_reg;
  logic                      rd_ok_reg;

  logic                      accept;
  logic                      addr_err;
  logic                      arr_we;
  logic                      arr_re;
  logic [IDX_W-1:0]          word_idx;
  logic [BUS_DATA_WIDTH-1:0] arr_rdata;

  assign accept   = bus.mem_req_i && (state_reg == MRESP_IDLE);
  assign addr_err = addr_out_of_range(bus.mem_addr_i, BASE_ADDR, SPAN);
  assign word_idx = IDX_W'((bus.mem_addr_i - BASE_ADDR) >> 2);
  assign arr_we   = accept && bus.mem_we_i && !addr_err;
  assign arr_re   = accept && !bus.mem_we_i && !addr_err;

  mem_resp_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (word_idx),
    .wmask (bus.mem_wmask_i),
    .wdata (bus.mem_wdata_i),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= MRESP_IDLE;
      cnt_reg    <= '0;
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rd_ok_reg  <= 1'b0;
    end else begin
      case (state_reg)
        MRESP_IDLE: begin
          if (bus.mem_req_i) begin
            err_reg   <= addr_err;
            rd_ok_reg <= !bus.mem_we_i && !addr_err;
            // Writes and erroneous accesses never need the array read port,
            // but an erroneous read still honours the read latency.
            if (bus.mem_we_i || READ_LAT == 1) begin
              state_reg  <= MRESP_RESP;
              rvalid_reg <= 1'b1;
            end else begin
              state_reg <= MRESP_WAIT;
              cnt_reg   <= CNT_INIT;
            end
          end
        end
        MRESP_WAIT: begin
          if (cnt_reg == 2'd0) begin
            state_reg  <= MRESP_RESP;
            rvalid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        MRESP_RESP: begin
          if (bus.mem_rready_i) begin
            state_reg  <= MRESP_IDLE;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            rd_ok_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg  <= MRESP_IDLE;
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
          rd_ok_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_ready_o  = (state_reg == MRESP_IDLE);
  assign bus.mem_rvalid_o = rvalid_reg;
  assign bus.mem_err_o    = rvalid_reg && err_reg;
  assign bus.mem_rdata_o  = (rvalid_reg && rd_ok_reg) ? arr_rdata : '0;

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning the byte address of word 0.
REQ-003 SHALL have parameter READ_LAT, default 1, meaning cycles from read acceptance to response valid (legal range 1..4).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port mem_req_i, input, 1, request valid (`RIB_REQ asserted).
REQ-007 SHALL have port mem_we_i, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port mem_addr_i, input, `BUS_ADDR_WIDTH, byte address.
REQ-009 SHALL have port mem_wdata_i, input, `BUS_DATA_WIDTH, byte-lane-aligned write data.
REQ-010 SHALL have port mem_wmask_i, input, 4, byte write enables; bit n selects byte n.
REQ-011 SHALL have port mem_ready_o, output, 1, request accepted this cycle when high together with mem_req_i.
REQ-012 SHALL have port mem_rvalid_o, output, 1, response valid.
REQ-013 SHALL have port mem_rdata_o, output, `BUS_DATA_WIDTH, read data (full word).
REQ-014 SHALL have port mem_err_o, output, 1, out-of-range access flag; qualified by mem_rvalid_o.
REQ-015 SHALL have port mem_rready_i, input, 1, response consumer ready.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP; mem_ready_o SHALL be 1 only in IDLE.
REQ-017 Handshake: a request SHALL be accepted on a rising edge where mem_req_i=1 and state=IDLE; inputs are sampled only at acceptance.
REQ-018 Word index SHALL be (mem_addr_i - BASE_ADDR)>>2; addr[1:0] SHALL be ignored, since lanes are selected by mem_wmask_i.
REQ-019 Range check: an address below BASE_ADDR or at/above BASE_ADDR+4*DEPTH is an error; the error SHALL be registered at acceptance.
REQ-020 In-range write SHALL update only the bytes whose mask bit is 1, at the acceptance edge.
REQ-021 A write with mask 4'b0000 SHALL leave the array unchanged and SHALL still respond.
REQ-022 An erroneous write SHALL leave the array unchanged.
REQ-023 Write path: IDLE->RESP on acceptance; mem_rvalid_o SHALL be 1 the next cycle, with mem_rdata_o=0.
REQ-024 Read path, READ_LAT=1: IDLE->RESP; mem_rvalid_o SHALL be 1 on the cycle after acceptance.
REQ-025 Read path, READ_LAT>1: IDLE->WAIT; a down-counter loaded with READ_LAT-2 SHALL hold the FSM in WAIT until zero, then go to RESP.
REQ-026 Read data SHALL reflect all writes accepted before the read.
REQ-027 An erroneous read SHALL return mem_rdata_o=0 and mem_err_o=1.
REQ-028 In RESP, mem_rvalid_o, mem_rdata_o and mem_err_o SHALL be held stable until mem_rready_i=1.
REQ-029 On the edge where mem_rready_i=1 in RESP, the FSM SHALL go to IDLE; a new request therefore cannot be accepted until the following cycle.
REQ-030 mem_rvalid_o SHALL be 0 in IDLE and WAIT; mem_rdata_o and mem_err_o SHALL be 0 whenever mem_rvalid_o=0.
REQ-031 mem_req_i changing while not ready SHALL have no effect; no request is queued.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, counter=0, mem_rvalid_o=0, mem_rdata_o=0, mem_err_o=0; mem_ready_o SHALL be 1 on the next cycle.
REQ-033 Reset in WAIT or RESP SHALL discard the pending response; an already-performed write SHALL remain in the array.
REQ-034 Array contents SHALL NOT be reset.

Structure
REQ-035 Bus width macros and `RIB_REQ SHALL come from defines.v; FSM state encodings SHALL be added there as `MRESP_IDLE/`MRESP_WAIT/`MRESP_RESP.
REQ-036 The storage array SHALL be a sub-module mem_resp_array: single-port, synchronous byte-masked write, registered read.

Verification
REQ-037 SW 0xDEADBEEF to 0x1000_0000, mask 1111; then LW 0x1000_0000 -> write ack rvalid 1 cycle later with err=0; read rdata=0xDEADBEEF.
REQ-038 SB with wdata=0x0000_AB00, mask 0010, to 0x1000_0001 over 0xDEADBEEF; then LW -> rdata=0xDEADABEF.
REQ-039 LW to 0x1000_1000 (DEPTH=1024) -> rvalid with err=1, rdata=0; array unchanged.
REQ-040 READ_LAT=3, LW, with mem_rready_i held 0 for 5 cycles -> rvalid rises 3 cycles after acceptance; rdata stable; ready_o=0 throughout; IDLE the cycle after rready=1.
REQ-041 rst asserted in WAIT -> next cycle rvalid=0 and ready_o=1; no response is ever delivered for the aborted read.
REQ-042 Write with mask 0000 -> ack delivered; subsequent LW returns the prior contents.
